// File: rtl/adc_period_analyzer_pkg.sv
// Shared types and field offsets for the ADC period analyzer.
// Both the top and the zero-cross detector import this package.
package adc_period_analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEAS_LOW  = 3'd3,
        ST_MEAS_HIGH = 3'd4
    } state_t;

    // cfg_data layout
    localparam int HYST_LSB      = 0;
    localparam int HYST_WIDTH    = 16;
    localparam int TIMEOUT_LSB   = 16;
    localparam int TIMEOUT_WIDTH = 32;
    localparam int EN_BIT        = 63;

    // result word layout
    localparam int PERIOD_LSB   = 0;
    localparam int MIN_LSB      = 32;
    localparam int MAX_LSB      = 48;
    localparam int RESULT_WIDTH = 64;

endpackage

// File: rtl/adc_period_analyzer_zero_cross_detector.sv
// Hysteresis comparator: flags samples at or below -H and at or above +H.
// Purely combinational; H is treated as an unsigned magnitude.
module zero_cross_detector
    import adc_period_analyzer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic signed [SAMPLE_WIDTH-1:0] i_sample,
    input  logic                           i_valid,
    input  logic        [HYST_WIDTH-1:0]   i_hyst,
    output logic                           o_below_lo,
    output logic                           o_above_hi
);

    // Two guard bits so that -H and +H both fit for any 16-bit magnitude.
    localparam int CW = ((SAMPLE_WIDTH > HYST_WIDTH) ? SAMPLE_WIDTH : HYST_WIDTH) + 2;

    logic signed [CW-1:0] w_x;
    logic signed [CW-1:0] w_hi;
    logic signed [CW-1:0] w_lo;

    assign w_x  = {{(CW-SAMPLE_WIDTH){i_sample[SAMPLE_WIDTH-1]}}, i_sample};
    assign w_hi = {{(CW-HYST_WIDTH){1'b0}}, i_hyst};
    assign w_lo = -w_hi;

    assign o_below_lo = i_valid && (w_x <= w_lo);
    assign o_above_hi = i_valid && (w_x >= w_hi);

endmodule

// File: rtl/adc_period_analyzer.sv
// Measures waveform period (in valid samples) between rising hysteresis crossings,
// tracks per-period min/max and emits one result word per period on AXIS.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | disabled; locked/overrun cleared, pending result dropped
// ST_ARM       | waiting for a sample at or below -H
// ST_WAIT_RISE | waiting for the first rising crossing (x >= +H)
// ST_MEAS_LOW  | period running, waiting for x <= -H
// ST_MEAS_HIGH | period running, next x >= +H closes the period
module adc_period_analyzer
    import adc_period_analyzer_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int ADC_WIDTH        = 14,
    parameter int PERIOD_WIDTH     = 32,
    parameter int CFG_DATA_WIDTH   = 64
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic [CFG_DATA_WIDTH-1:0]   cfg_data,
    output logic [RESULT_WIDTH-1:0]     m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        locked,
    output logic                        overrun
);

    state_t                              r_state;
    logic        [PERIOD_WIDTH-1:0]      r_cnt;
    logic signed [AXIS_TDATA_WIDTH-1:0]  r_min;
    logic signed [AXIS_TDATA_WIDTH-1:0]  r_max;
    logic        [RESULT_WIDTH-1:0]      r_tdata;
    logic                                r_tvalid;
    logic                                r_locked;
    logic                                r_overrun;

    logic signed [AXIS_TDATA_WIDTH-1:0]  w_x;
    logic                                w_en;
    logic        [HYST_WIDTH-1:0]        w_hyst;
    logic        [TIMEOUT_WIDTH-1:0]     w_timeout;
    logic                                w_below;
    logic                                w_above;
    logic        [PERIOD_WIDTH:0]        w_cnt_inc;
    logic        [PERIOD_WIDTH-1:0]      w_cnt_next;
    logic                                w_timeout_hit;
    logic signed [AXIS_TDATA_WIDTH-1:0]  w_min_next;
    logic signed [AXIS_TDATA_WIDTH-1:0]  w_max_next;
    logic                                w_slot_free;
    logic        [RESULT_WIDTH-1:0]      w_result;
    logic        [CFG_DATA_WIDTH-EN_BIT+AXIS_TDATA_WIDTH-ADC_WIDTH-1+EN_BIT-TIMEOUT_LSB-TIMEOUT_WIDTH:0] w_unused_bits;

    assign w_x       = {{(AXIS_TDATA_WIDTH-ADC_WIDTH){s_axis_tdata[ADC_WIDTH-1]}},
                        s_axis_tdata[ADC_WIDTH-1:0]};
    assign w_en      = cfg_data[EN_BIT];
    assign w_hyst    = cfg_data[HYST_LSB +: HYST_WIDTH];
    assign w_timeout = cfg_data[TIMEOUT_LSB +: TIMEOUT_WIDTH];
    assign w_unused_bits = {cfg_data[EN_BIT-1:TIMEOUT_LSB+TIMEOUT_WIDTH],
                            s_axis_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH]};

    zero_cross_detector #(
        .SAMPLE_WIDTH (AXIS_TDATA_WIDTH)
    ) u_zero_cross_detector (
        .i_sample   (w_x),
        .i_valid    (s_axis_tvalid),
        .i_hyst     (w_hyst),
        .o_below_lo (w_below),
        .o_above_hi (w_above)
    );

    // Extra MSB in the increment lets the counter saturate instead of wrapping.
    assign w_cnt_inc     = {1'b0, r_cnt} + {{PERIOD_WIDTH{1'b0}}, 1'b1};
    assign w_cnt_next    = w_cnt_inc[PERIOD_WIDTH] ? {PERIOD_WIDTH{1'b1}} : w_cnt_inc[PERIOD_WIDTH-1:0];
    assign w_timeout_hit = (w_timeout != '0) && (w_cnt_inc >= (PERIOD_WIDTH+1)'(w_timeout));

    assign w_min_next  = (w_x < r_min) ? w_x : r_min;
    assign w_max_next  = (w_x > r_max) ? w_x : r_max;
    assign w_slot_free = !r_tvalid || m_axis_tready;

    always_comb begin
        w_result = '0;
        w_result[PERIOD_LSB +: PERIOD_WIDTH]  = w_cnt_next;
        w_result[MIN_LSB +: AXIS_TDATA_WIDTH] = w_min_next;
        w_result[MAX_LSB +: AXIS_TDATA_WIDTH] = w_max_next;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_locked  <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!w_en) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_tvalid  <= 1'b0;
            r_locked  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            if (s_axis_tvalid) begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_below) begin
                            r_state <= ST_WAIT_RISE;
                        end
                    end
                    ST_WAIT_RISE: begin
                        if (w_above) begin
                            r_state <= ST_MEAS_LOW;
                            r_cnt   <= '0;
                            r_min   <= w_x;
                            r_max   <= w_x;
                        end
                    end
                    ST_MEAS_LOW, ST_MEAS_HIGH: begin
                        // Timeout wins over a crossing on the same sample: no result.
                        if (w_timeout_hit) begin
                            r_state  <= ST_ARM;
                            r_locked <= 1'b0;
                            r_cnt    <= '0;
                        end else if ((r_state == ST_MEAS_HIGH) && w_above) begin
                            if (w_slot_free) begin
                                r_tdata  <= w_result;
                                r_tvalid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_state  <= ST_MEAS_LOW;
                            r_cnt    <= '0;
                            r_min    <= w_x;
                            r_max    <= w_x;
                            r_locked <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_next;
                            r_min <= w_min_next;
                            r_max <= w_max_next;
                            if ((r_state == ST_MEAS_LOW) && w_below) begin
                                r_state <= ST_MEAS_HIGH;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign locked        = r_locked;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_adc_period_analyzer.sv
// Bench for adc_period_analyzer: table of square-wave vectors, hand sequences for
// backpressure/timeout/valid gaps/async reset, and randomized traffic vs a sample-level model.
module tb_adc_period_analyzer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [63:0] cfg_data;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        locked;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_period_analyzer dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .cfg_data      (cfg_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .locked        (locked),
        .overrun       (overrun)
    );

    // Model: phase 0 = disabled, 1 = needs a low sample, 2 = needs first high, 3 = tracking.
    int          ph;
    longint      m_since;
    int          m_lo;
    int          m_hi;
    bit          m_seen_low;
    bit          m_lock;
    bit          m_ovr;
    bit          m_valid;
    logic [63:0] m_word;

    bit          cap_got;
    logic [63:0] cap_word;

    typedef struct {
        int hi;
        int lo;
        int n_hi;
        int n_lo;
        int hyst;
        int exp_period;
        int exp_min;
        int exp_max;
        bit exp_lock;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [63:0] mk_cfg(bit en, int unsigned t, int unsigned h);
        logic [15:0] hh;
        hh = h[15:0];
        return {en, 15'd0, t, hh};
    endfunction

    function automatic logic [63:0] mk_word(int mx, int mn, int per);
        return {16'(mx), 16'(mn), 32'(per)};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; m_since = 0; m_lo = 0; m_hi = 0; m_seen_low = 0;
        m_lock = 0; m_ovr = 0; m_valid = 0; m_word = '0;
    endtask

    task automatic model_step();
        int          x;
        int          h;
        longint      t;
        logic [63:0] w;
        if (!aresetn) begin
            model_reset();
            return;
        end
        if (!cfg_data[63]) begin
            ph = 0; m_lock = 0; m_ovr = 0; m_valid = 0; m_since = 0;
            return;
        end
        h = int'(cfg_data[15:0]);
        t = longint'(cfg_data[47:16]);
        x = int'($signed(s_axis_tdata[13:0]));
        if (m_valid && m_axis_tready) m_valid = 0;
        if (!s_axis_tvalid) return;
        if (ph == 0) begin
            ph = 1;
        end else if (ph == 1) begin
            if (x <= -h) ph = 2;
        end else if (ph == 2) begin
            if (x >= h) begin
                ph = 3; m_since = 0; m_lo = x; m_hi = x; m_seen_low = 0;
            end
        end else begin
            m_since++;
            if (t != 0 && m_since >= t) begin
                ph = 1; m_lock = 0;
            end else if (m_seen_low && x >= h) begin
                w = mk_word((x > m_hi) ? x : m_hi, (x < m_lo) ? x : m_lo, int'(m_since));
                if (!m_valid) begin
                    m_word = w; m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
                m_since = 0; m_lo = x; m_hi = x; m_seen_low = 0; m_lock = 1;
            end else begin
                if (x < m_lo) m_lo = x;
                if (x > m_hi) m_hi = x;
                if (x <= -h) m_seen_low = 1;
            end
        end
    endtask

    task automatic check_outputs();
        cmp("tvalid", m_axis_tvalid, m_valid);
        cmp("locked", locked, m_lock);
        cmp("overrun", overrun, m_ovr);
        if (m_valid) cmp("tdata", m_axis_tdata, m_word);
        if (m_axis_tvalid && !cap_got) begin
            cap_got  = 1;
            cap_word = m_axis_tdata;
        end
    endtask

    task automatic step(input logic [15:0] d, input bit v, input bit rdy);
        s_axis_tdata  = d;
        s_axis_tvalid = v;
        m_axis_tready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // n valid samples of value val; in gap mode each is followed by an invalid junk cycle.
    task automatic run_level(input int val, input int n, input bit gaps, input bit rdy);
        for (int k = 0; k < n; k++) begin
            step(16'(val), 1'b1, rdy);
            if (gaps) step(16'($urandom), 1'b0, rdy);
        end
    endtask

    task automatic disable_cycles(input int n);
        cfg_data[63] = 1'b0;
        for (int k = 0; k < n; k++) step(16'($urandom), 1'b1, 1'b1);
    endtask

    initial begin
        vecs[0] = '{4000, -4000, 10, 10, 100, 20, -4000, 4000, 1'b1};
        vecs[1] = '{1000, -2000,  7,  5, 500, 12, -2000, 1000, 1'b1};
        vecs[2] = '{ 200,  -200,  4,  9, 200, 13,  -200,  200, 1'b1};
        vecs[3] = '{ 200,  -200,  4,  9, 201,  0,     0,    0, 1'b0};
        vecs[4] = '{8191, -8192,  3,  3,   0,  6, -8192, 8191, 1'b1};

        aresetn = 1'b0;
        cfg_data = '0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        model_reset();
        cap_got = 0;
        cap_word = '0;
        #12;
        cmp("rst_tdata", m_axis_tdata, 64'd0);
        cmp("rst_tvalid", m_axis_tvalid, 1'b0);
        cmp("rst_locked", locked, 1'b0);
        cmp("rst_overrun", overrun, 1'b0);
        aresetn = 1'b1;

        // Square-wave vectors, tready held high.
        for (int i = 0; i < 5; i++) begin
            cfg_data = mk_cfg(1'b0, 0, vecs[i].hyst);
            disable_cycles(2);
            cfg_data = mk_cfg(1'b1, 0, vecs[i].hyst);
            cap_got = 0;
            for (int p = 0; p < 5; p++) begin
                run_level(vecs[i].lo, vecs[i].n_lo, 1'b0, 1'b1);
                run_level(vecs[i].hi, vecs[i].n_hi, 1'b0, 1'b1);
            end
            cmp($sformatf("vec%0d_seen", i), cap_got, vecs[i].exp_lock);
            cmp($sformatf("vec%0d_locked", i), locked, vecs[i].exp_lock);
            if (vecs[i].exp_lock)
                cmp($sformatf("vec%0d_word", i), cap_word,
                    mk_word(vecs[i].exp_max, vecs[i].exp_min, vecs[i].exp_period));
        end

        // Noise inside the hysteresis band never arms a measurement.
        cfg_data = mk_cfg(1'b0, 0, 100);
        disable_cycles(2);
        cfg_data = mk_cfg(1'b1, 0, 100);
        cap_got = 0;
        for (int k = 0; k < 200; k++)
            step(16'(int'($urandom_range(0, 100)) - 50), 1'b1, 1'b1);
        cmp("noise_no_result", cap_got, 1'b0);
        cmp("noise_locked", locked, 1'b0);

        // Backpressure: first word held, second dropped, overrun sticky until disable.
        cfg_data = mk_cfg(1'b0, 0, 100);
        disable_cycles(2);
        cfg_data = mk_cfg(1'b1, 0, 100);
        run_level(-4000, 10, 1'b0, 1'b1);
        run_level(4000, 10, 1'b0, 1'b1);
        run_level(-4000, 10, 1'b0, 1'b1);
        run_level(4000, 10, 1'b0, 1'b0);
        run_level(-4000, 10, 1'b0, 1'b0);
        run_level(4000, 1, 1'b0, 1'b0);
        cmp("bp_tvalid_held", m_axis_tvalid, 1'b1);
        cmp("bp_word_held", m_axis_tdata, mk_word(4000, -4000, 20));
        cmp("bp_overrun_set", overrun, 1'b1);
        run_level(4000, 1, 1'b0, 1'b1);
        cmp("bp_tvalid_drop", m_axis_tvalid, 1'b0);
        cmp("bp_overrun_sticky", overrun, 1'b1);
        run_level(4000, 5, 1'b0, 1'b1);
        cmp("bp_overrun_still", overrun, 1'b1);
        disable_cycles(1);
        cmp("bp_overrun_clear", overrun, 1'b0);

        // Timeout: locked drops on the 50th sample after the last crossing.
        cfg_data = mk_cfg(1'b1, 50, 100);
        run_level(-4000, 10, 1'b0, 1'b1);
        for (int p = 0; p < 2; p++) begin
            run_level(4000, 10, 1'b0, 1'b1);
            run_level(-4000, 10, 1'b0, 1'b1);
        end
        run_level(4000, 1, 1'b0, 1'b1);
        run_level(0, 49, 1'b0, 1'b1);
        cmp("to_locked_before", locked, 1'b1);
        run_level(0, 1, 1'b0, 1'b1);
        cmp("to_locked_after", locked, 1'b0);
        cmp("to_no_result", m_axis_tvalid, 1'b0);
        run_level(-4000, 10, 1'b0, 1'b1);
        run_level(4000, 10, 1'b0, 1'b1);
        run_level(-4000, 10, 1'b0, 1'b1);
        run_level(4000, 1, 1'b0, 1'b1);
        cmp("to_relock", locked, 1'b1);

        // Valid gaps are invisible to the period measurement.
        cfg_data = mk_cfg(1'b0, 0, 100);
        disable_cycles(2);
        cfg_data = mk_cfg(1'b1, 0, 100);
        cap_got = 0;
        for (int p = 0; p < 4; p++) begin
            run_level(-4000, 10, 1'b1, 1'b1);
            run_level(4000, 10, 1'b1, 1'b1);
        end
        cmp("gap_seen", cap_got, 1'b1);
        cmp("gap_word", cap_word, mk_word(4000, -4000, 20));

        // Asynchronous reset in MEAS_HIGH clears outputs without a clock edge.
        cfg_data = mk_cfg(1'b1, 0, 100);
        run_level(-4000, 10, 1'b0, 1'b1);
        run_level(4000, 10, 1'b0, 1'b1);
        run_level(-4000, 5, 1'b0, 1'b1);
        #3;
        aresetn = 1'b0;
        #1;
        cmp("arst_tdata", m_axis_tdata, 64'd0);
        cmp("arst_tvalid", m_axis_tvalid, 1'b0);
        cmp("arst_locked", locked, 1'b0);
        cmp("arst_overrun", overrun, 1'b0);
        model_reset();
        run_level(-4000, 2, 1'b0, 1'b1);
        aresetn = 1'b1;
        cap_got = 0;
        run_level(-4000, 5, 1'b0, 1'b1);
        run_level(4000, 10, 1'b0, 1'b1);
        run_level(-4000, 10, 1'b0, 1'b1);
        cmp("arst_no_early", cap_got, 1'b0);
        run_level(4000, 1, 1'b0, 1'b1);
        cmp("arst_first_result", cap_got, 1'b1);
        cmp("arst_word", cap_word, mk_word(4000, -4000, 20));

        // Randomized traffic against the model.
        for (int r = 0; r < 4; r++) begin
            int          h;
            int          t;
            int          level;
            int          rem;
            int          amp;
            int          val;
            logic [15:0] d;
            h = int'($urandom_range(0, 1500));
            t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(15, 250));
            cfg_data = mk_cfg(1'b0, t, h);
            disable_cycles(2);
            cfg_data = mk_cfg(1'b1, t, h);
            level = 1;
            rem = 0;
            amp = 0;
            for (int k = 0; k < 1500; k++) begin
                if (rem == 0) begin
                    level = -level;
                    rem = int'($urandom_range(2, 40));
                    amp = int'($urandom_range(0, 8000));
                end
                rem--;
                val = level * amp + int'($urandom_range(0, 600)) - 300;
                if (val > 8191) val = 8191;
                if (val < -8192) val = -8192;
                d = 16'(val);
                d[15:14] = 2'($urandom_range(0, 3));
                cfg_data[63] = ($urandom_range(0, 699) != 0);
                step(d, ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_period_analyzer.md
Name: adc_period_analyzer

Overview:
- Receive-side counterpart to the DAC signal generator. Consumes the ADC sample stream on AXIS.
- Detects rising zero crossings with configurable hysteresis and measures the period, in samples, of the incoming waveform.
- Also tracks min/max amplitude per period and emits one 64-bit result word per period on an AXIS master with backpressure.
- Used to verify generator output in loopback and for frequency/amplitude readback via the cfg/status path.

Parameters:
AXIS_TDATA_WIDTH, 16, sample bus width (signed).
ADC_WIDTH, 14, valid sample bits; bits [ADC_WIDTH-1:0], sign-extended to AXIS_TDATA_WIDTH.
PERIOD_WIDTH, 32, period counter width.
CFG_DATA_WIDTH, 64, configuration word width.

Ports:
clk  in  1  sample clock, 125 MHz; all logic on rising edge.
aresetn  in  1  reset; asynchronous assertion, active-low.
s_axis_tdata  in  AXIS_TDATA_WIDTH  ADC sample.
s_axis_tvalid  in  1  sample qualifier; no tready (ADC cannot stall).
cfg_data  in  CFG_DATA_WIDTH  [15:0] hysteresis H (unsigned); [47:16] timeout T in samples (0 = disabled); [63] enable.
m_axis_tdata  out  64  {max[63:48], min[47:32], period[31:0]}.
m_axis_tvalid  out  1  result valid.
m_axis_tready  in  1  result accepted.
locked  out  1  a valid period is being tracked.
overrun  out  1  sticky: a result was dropped.

Behaviour:
- Reset, asynchronous and active-low: all state to IDLE. m_axis_tdata=0, m_axis_tvalid=0, locked=0, overrun=0, counters=0.
- Only cycles with s_axis_tvalid=1 advance counters or states. Gaps in tvalid are invisible to the measurement.
- Comparisons are signed on the sign-extended sample x against +H and -H. H is interpreted as a positive 16-bit value.
- FSM states: IDLE, ARM, WAIT_RISE, MEAS_LOW, MEAS_HIGH.
  - IDLE: entered while enable=0. Holds locked=0, clears overrun, drops any pending result (tvalid=0). Exits to ARM when enable=1.
  - ARM -> WAIT_RISE on x <= -H.
  - WAIT_RISE -> MEAS_LOW on x >= +H (first crossing). On that sample: period counter=0, min=max=x.
  - MEAS_LOW -> MEAS_HIGH on x <= -H.
  - MEAS_HIGH on x >= +H (rising crossing):
    - Emits result: period = counter+1, with min/max including this sample.
    - Then period counter=0, min=max=x, locked=1, return to MEAS_LOW.
  - In MEAS_LOW/MEAS_HIGH, each valid sample: counter+1, saturating at all-ones; min/max updated.
  - Timeout: T!=0 and counter+1 >= T in MEAS_* -> locked=0, go to ARM, no result emitted.
  - enable=0 in any state -> IDLE on the next edge.
- Latency: the crossing sample is accepted at edge N; m_axis_tvalid=1 and data are visible after edge N.
- Output slot is a single register.
  - Loads when (!m_axis_tvalid || m_axis_tready).
  - Transfer happens on tvalid && tready; tvalid then drops unless a new result loads in the same cycle.
  - A new result with tready low and a full slot: held word is kept, new result dropped, overrun=1 (sticky until IDLE or reset).
- Arithmetic: min/max signed 16-bit. Period counter is unsigned PERIOD_WIDTH and saturates; no wrap.

Decomposition:
- Shared package holds:
  - FSM state encoding, 3 bits.
  - cfg field offsets: HYST_LSB=0, TIMEOUT_LSB=16, EN_BIT=63.
  - Result field offsets: PERIOD_LSB=0, MIN_LSB=32, MAX_LSB=48.
- One sub-module: zero_cross_detector.
  - Inputs: sample, valid, H.
  - Outputs: registered-free below_lo/above_hi flags.
  - Lets hysteresis compare logic be verified alone.
- Top holds the FSM, counters, min/max and output slot.

Test Plan:
1. Square wave, 10 samples -4000 / 10 samples +4000, H=100, T=0, tready=1. Required: after arming, results every 20 samples, each {max=4000, min=-4000, period=20}; locked=1 from the second rising crossing.
2. Noise within ±50, H=100. Required: no output, locked=0, FSM stays in ARM/WAIT_RISE.
3. Test 1 stimulus with tready=0 across two crossings. Required: first word held unchanged; second dropped; overrun=1. Then tready=1 for one cycle: tvalid drops; overrun stays 1 until enable=0.
4. Test 1 locked, then constant 0 input with T=50. Required: locked falls after the 50th sample past the last crossing; no spurious result; re-lock on restart.
5. Test 1 with s_axis_tvalid toggling every other cycle. Required: period still 20; result emitted one cycle after each crossing sample.
6. aresetn pulsed low mid-MEAS_HIGH, asynchronously. Required: outputs 0 immediately without a clock edge. After release, two rising crossings are needed before the next result.
